// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - opcode, REGIMM and PC-source constants for the branch predict unit
package branch_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef enum logic [1:0] {
        PC_SEQ     = 2'b00,
        PC_JUMP    = 2'b01,
        PC_BRANCH  = 2'b10,
        PC_RECOVER = 2'b11
    } pcSrcE;

    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [1:0] satStep(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        nxt = cnt;
        if (up && cnt != 2'b11) begin
            nxt = cnt + 2'b01;
        end else if (!up && cnt != 2'b00) begin
            nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch lookup, EX resolve and redirect signals of the branch predict unit
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  inFetchPC;
    logic             outPredTaken;
    logic             inBranch;
    logic [5:0]       inOp;
    logic [4:0]       inRtField;
    logic [XLEN-1:0]  inRsVal;
    logic [XLEN-1:0]  inRtVal;
    logic [XLEN-1:0]  inBrPC;
    logic             inBrPredTaken;
    logic [1:0]       inPCsrc;
    logic [1:0]       outPCsrc;
    logic             outFlush;
    logic [CNT_W-1:0] outMispredCount;

    modport master (
        output inFetchPC, inBranch, inOp, inRtField, inRsVal, inRtVal,
               inBrPC, inBrPredTaken, inPCsrc,
        input  outPredTaken, outPCsrc, outFlush, outMispredCount
    );

    modport slave (
        input  inFetchPC, inBranch, inOp, inRtField, inRsVal, inRtVal,
               inBrPC, inBrPredTaken, inPCsrc,
        output outPredTaken, outPCsrc, outFlush, outMispredCount
    );
endinterface

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition evaluation for BEQ/BNE/BLEZ/BGTZ/BGEZ/BLTZ
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op,
    input  logic [4:0]      rtField,
    input  logic [XLEN-1:0] rsVal,
    input  logic [XLEN-1:0] rtVal,
    output logic            taken,
    output logic            legal
);
    logic rsNeg;
    logic rsZero;

    assign rsNeg  = rsVal[XLEN-1];
    assign rsZero = (rsVal == '0);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        unique case (op)
            OP_BEQ:  taken = (rsVal == rtVal);
            OP_BNE:  taken = (rsVal != rtVal);
            OP_BLEZ: taken = rsNeg | rsZero;
            OP_BGTZ: taken = !rsNeg && !rsZero;
            OP_REGIMM: begin
                if (rtField == RT_BGEZ) begin
                    taken = !rsNeg;
                end else if (rtField == RT_BLTZ) begin
                    taken = rsNeg;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit BHT predictor with EX-stage resolve, redirect/flush and mispredict count
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int BHT_IDX = 6,
    parameter int CNT_W   = 16
) (
    input  logic inClk,
    input  logic inRstN,
    branch_predict_unit_if.slave bus
);
    localparam int ENTRIES = 1 << BHT_IDX;

    logic [1:0]         bht [ENTRIES];
    logic [BHT_IDX-1:0] fetchIdx;
    logic [BHT_IDX-1:0] brIdx;
    logic               condTaken;
    logic               condLegal;
    logic               outcome;
    logic               squash;
    logic               resolve;
    logic               mispred;
    pcSrcE              pcSrcD;
    pcSrcE              pcSrcQ;
    logic               flushD;
    logic               flushQ;
    logic [CNT_W-1:0]   countQ;
    logic               unusedPcBits;

    assign fetchIdx = bus.inFetchPC[BHT_IDX+1:2];
    assign brIdx    = bus.inBrPC[BHT_IDX+1:2];
    assign unusedPcBits = ^{bus.inFetchPC[XLEN-1:BHT_IDX+2], bus.inFetchPC[1:0],
                            bus.inBrPC[XLEN-1:BHT_IDX+2], bus.inBrPC[1:0]};

    // Combinational read of the registered array gives the pre-update value on a same-index collision.
    assign bus.outPredTaken = bht[fetchIdx][1];

    branch_cond #(.XLEN(XLEN)) uCond (
        .op      (bus.inOp),
        .rtField (bus.inRtField),
        .rsVal   (bus.inRsVal),
        .rtVal   (bus.inRtVal),
        .taken   (condTaken),
        .legal   (condLegal)
    );

    // Whatever arrives while a flush is on the bus is a wrong-path instruction.
    assign squash  = flushQ;
    assign outcome = condTaken & condLegal;
    assign resolve = bus.inBranch & condLegal & ~squash;
    assign mispred = bus.inBranch & ~squash & (outcome != bus.inBrPredTaken);

    always_comb begin
        pcSrcD = PC_SEQ;
        flushD = 1'b0;
        if (!squash) begin
            if (bus.inBranch) begin
                if (mispred) begin
                    pcSrcD = outcome ? PC_BRANCH : PC_RECOVER;
                    flushD = 1'b1;
                end
            end else begin
                pcSrcD = pcSrcE'(bus.inPCsrc);
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (!inRstN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_INIT;
            end
            pcSrcQ <= PC_SEQ;
            flushQ <= 1'b0;
            countQ <= '0;
        end else begin
            if (resolve) begin
                bht[brIdx] <= satStep(bht[brIdx], condTaken);
            end
            pcSrcQ <= pcSrcD;
            flushQ <= flushD;
            if (flushD && !(&countQ)) begin
                countQ <= countQ + 1'b1;
            end
        end
    end

    assign bus.outPCsrc        = pcSrcQ;
    assign bus.outFlush        = flushQ;
    assign bus.outMispredCount = countQ;
endmodule
